// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared constants, state encoding and lane seed derivation for prbs_gen
package prbs_pkg;
   localparam int LANES  = 128;
   localparam int LFSR_W = 32;

   localparam int TAP_A = 31;
   localparam int TAP_B = 21;
   localparam int TAP_C = 1;
   localparam int TAP_D = 0;

   localparam logic [31:0] SEED_MUL = 32'h9E3779B9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Bit 0 is forced high so no lane can start in the all-zero lock-up state.
   function automatic logic [LFSR_W-1:0] lane_seed(input logic [LFSR_W-1:0] seed, input int lane);
      logic [LFSR_W-1:0] prod;
      prod = LFSR_W'(lane) * SEED_MUL;
      return (seed ^ prod) | LFSR_W'(1);
   endfunction
endpackage

// File: rtl/prbs_lfsr_tx.sv
// rtl/prbs_lfsr_tx.sv - one 32-bit Fibonacci LFSR lane (taps 31,21,1,0), advances only on i_adv
module prbs_lfsr_tx
   import prbs_pkg::*;
#(
   parameter logic [31:0] SEED = 32'h1
) (
   input  logic ck,
   input  logic rst,
   input  logic i_adv,
   output logic o_bit
);

   logic [LFSR_W-1:0] s;
   logic              fb;

   assign fb    = s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
   assign o_bit = fb;

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         s <= SEED;
      end else if (i_adv) begin
         s <= {s[LFSR_W-2:0], fb};
      end
   end

endmodule

// File: rtl/prbs_gen.sv
// rtl/prbs_gen.sv - 128-lane PRBS word source with burst/continuous run control and ready throttle
// Optional single-bit error injection is built when PRBS_ERR_INJ_EN is defined.
module prbs_gen #(
   parameter logic [31:0] SEED  = 32'h1,
   parameter int          LANES = prbs_pkg::LANES
) (
   input  logic        ck,
   input  logic        rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [31:0] i_cnt,
   input  logic        i_rdy,
   input  logic        i_inj_err,
   output logic        o_req,
   output logic [63:0] o_dout_lower,
   output logic [63:0] o_dout_upper,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_word_cnt
);
   import prbs_pkg::*;

   state_t             state, state_nxt;
   logic               issue;
   logic               start_ok;
   logic [31:0]        cnt_q;
   logic [31:0]        word_cnt;
   logic [LANES-1:0]   lane_bit;
   logic [LANES-1:0]   word;
   logic [LANES-1:0]   inj_mask;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      prbs_lfsr_tx #(
         .SEED (lane_seed(SEED, g))
      ) u_lane (
         .ck    (ck),
         .rst   (rst),
         .i_adv (issue),
         .o_bit (lane_bit[g])
      );
   end

   assign start_ok = i_start && !i_stop;

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Stop takes priority over issuing: on a stop edge no word leaves and no lane advances.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) state_nxt = RUN;
         end
         RUN: begin
            if (i_stop) begin
               state_nxt = DONE;
            end else if (i_rdy) begin
               issue = 1'b1;
               if ((cnt_q != 32'd0) && ((word_cnt + 32'd1) == cnt_q)) state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

`ifdef PRBS_ERR_INJ_EN
   logic inj_pending;

   // A request arriving on the same edge that consumes the pending flag arms the following word.
   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         inj_pending <= 1'b0;
      end else if (issue) begin
         inj_pending <= i_inj_err;
      end else if (i_inj_err) begin
         inj_pending <= 1'b1;
      end
   end

   assign inj_mask = {{(LANES-1){1'b0}}, inj_pending};
`else
   logic unused_inj;
   assign unused_inj = i_inj_err;
   assign inj_mask   = '0;
`endif

   always_ff @(posedge ck or posedge rst) begin
      if (rst) begin
         cnt_q    <= 32'd0;
         word_cnt <= 32'd0;
         word     <= '0;
         o_req    <= 1'b0;
         o_done   <= 1'b0;
      end else begin
         o_req  <= issue;
         o_done <= (state == DONE);
         if ((state == IDLE) && start_ok) begin
            cnt_q    <= i_cnt;
            word_cnt <= 32'd0;
         end
         if (issue) begin
            word     <= lane_bit ^ inj_mask;
            word_cnt <= word_cnt + 32'd1;
         end
      end
   end

   assign o_busy       = (state != IDLE);
   assign o_word_cnt   = word_cnt;
   assign o_dout_lower = word[63:0];
   assign o_dout_upper = word[127:64];

endmodule
